eth_mdio_master: RTL and testbench

- Hardware MDIO (IEEE 802.3 clause 22) management master for the RGMII PHY attached to the Ethernet framing block.
- Replaces software bit-banging of phy_mdclk/phy_mdio_o/phy_mdio_oe.
- Accepts one read or write command at a time from the framing register file.
- Serialises the frame on MDC/MDIO and returns read data plus a no-PHY error flag.

---
 rtl/eth_mdio_master.sv | 153 +++++++++++++++
 tb/tb_eth_mdio_master.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_mdio_master.sv
// Clause-22 MDIO master: serialises one read/write frame on MDC/MDIO, returns read data and a no-PHY flag.
// Latency: accept at cycle A gives rsp_valid at A + 1 + (PREAMBLE_LEN+32)*2*CLK_DIV.
// Backpressure: cmd_ready is low for the whole frame; cmd_valid while busy is ignored and must be held.
module eth_mdio_master #(
  parameter int CLK_DIV      = 10,
  parameter int PREAMBLE_LEN = 32
) (
  input  logic        msoc_clk,
  input  logic        rst_int,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [4:0]  cmd_phy_addr,
  input  logic [4:0]  cmd_reg_addr,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        phy_mdc,
  output logic        phy_mdio_o,
  output logic        phy_mdio_oe,
  input  logic        phy_mdio_i
);

  localparam int N      = PREAMBLE_LEN + 32;
  // Index of the first turnaround bit (after ST, OP, PHYAD, REGAD).
  localparam int TA_BIT = PREAMBLE_LEN + 14;
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [5:0] BIT_LAST = 6'(N - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t      state;
  logic [7:0]  div;
  logic [5:0]  bit_cnt;
  logic        high_half;
  logic [31:0] frame;
  logic        is_write;
  logic [15:0] rd_sh;
  logic        err_sh;
  logic [1:0]  mdio_sync;
  logic        mdio_s;
  logic [15:0] rd_next;
  logic [1:0]  cmd_first;
  logic [1:0]  next_drv;

  // Post-preamble 32-bit frame; read frames carry zeros in TA/DATA since those bits are not driven.
  function automatic logic [31:0] make_frame(input logic wr, input logic [4:0] pa,
                                             input logic [4:0] ra, input logic [15:0] wd);
    return {2'b01, (wr ? 2'b01 : 2'b10), pa, ra, (wr ? 2'b10 : 2'b00), (wr ? wd : 16'h0000)};
  endfunction

  // {oe, o} for bit idx of the full frame including preamble.
  function automatic logic [1:0] drive_bit(input logic [31:0] w, input logic wr, input int idx);
    int k;
    logic [4:0] pos;
    k = idx - PREAMBLE_LEN;
    if (k < 0) return 2'b11;
    if (!wr && k >= 14) return 2'b00;
    pos = 5'(31 - k);
    return {1'b1, w[pos]};
  endfunction

  assign mdio_s  = mdio_sync[1];
  assign rd_next = {rd_sh[14:0], mdio_s};
  assign busy    = !cmd_ready;

  // Drive values for bit 0 of a new command and for the bit that follows the current one.
  always_comb begin
    cmd_first = drive_bit(make_frame(cmd_write, cmd_phy_addr, cmd_reg_addr, cmd_wdata), cmd_write, 0);
    next_drv  = drive_bit(frame, is_write, int'(bit_cnt) + 1);
  end

  // Two-flop synchroniser on the shared MDIO input.
  always_ff @(posedge msoc_clk or posedge rst_int) begin
    if (rst_int) mdio_sync <= 2'b00;
    else         mdio_sync <= {mdio_sync[0], phy_mdio_i};
  end

  // Frame sequencer: MDC divider, bit counter, MDIO drive and read capture.
  always_ff @(posedge msoc_clk or posedge rst_int) begin
    if (rst_int) begin
      state       <= IDLE;
      cmd_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= 16'h0000;
      rsp_err     <= 1'b0;
      phy_mdc     <= 1'b0;
      phy_mdio_o  <= 1'b0;
      phy_mdio_oe <= 1'b0;
      div         <= 8'd0;
      bit_cnt     <= 6'd0;
      high_half   <= 1'b0;
      frame       <= 32'h0;
      is_write    <= 1'b0;
      rd_sh       <= 16'h0000;
      err_sh      <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            frame                     <= make_frame(cmd_write, cmd_phy_addr, cmd_reg_addr, cmd_wdata);
            is_write                  <= cmd_write;
            state                     <= SHIFT;
            cmd_ready                 <= 1'b0;
            div                       <= 8'd0;
            bit_cnt                   <= 6'd0;
            high_half                 <= 1'b0;
            phy_mdc                   <= 1'b0;
            {phy_mdio_oe, phy_mdio_o} <= cmd_first;
            rsp_rdata                 <= 16'h0000;
            rsp_err                   <= 1'b0;
            rd_sh                     <= 16'h0000;
            err_sh                    <= 1'b0;
          end
        end
        SHIFT: begin
          if (div != DIV_LAST) begin
            div <= div + 8'd1;
          end else begin
            div <= 8'd0;
            if (!high_half) begin
              high_half <= 1'b1;
              phy_mdc   <= 1'b1;
            end else begin
              // Last cycle of the high half: sample the synchronised input.
              if (!is_write && int'(bit_cnt) == TA_BIT + 1) err_sh <= mdio_s;
              if (!is_write && int'(bit_cnt) >= TA_BIT + 2) rd_sh  <= rd_next;
              high_half <= 1'b0;
              phy_mdc   <= 1'b0;
              if (bit_cnt == BIT_LAST) begin
                state       <= IDLE;
                cmd_ready   <= 1'b1;
                rsp_valid   <= 1'b1;
                phy_mdio_o  <= 1'b0;
                phy_mdio_oe <= 1'b0;
                rsp_rdata   <= is_write ? 16'h0000 : rd_next;
                rsp_err     <= is_write ? 1'b0 : err_sh;
              end else begin
                bit_cnt                   <= bit_cnt + 6'd1;
                {phy_mdio_oe, phy_mdio_o} <= next_drv;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_mdio_master.sv
// Self-checking bench for eth_mdio_master: randomized and directed frames against a frame-level model.
// Two instances: CLK_DIV=2/PREAMBLE_LEN=32 (main) and CLK_DIV=3/PREAMBLE_LEN=0 (no preamble).
// A PHY model answers reads; a monitor records MDIO at MDC rises, accepts and responses.
module tb_eth_mdio_master;

  localparam int CD     = 2;
  localparam int PRE    = 32;
  localparam int NB     = PRE + 32;
  localparam int LAT    = 1 + NB * 2 * CD;
  localparam int CD_B   = 3;
  localparam int LAT_B  = 1 + 32 * 2 * CD_B;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [4:0]  cmd_phy_addr, cmd_reg_addr;
  logic [15:0] cmd_wdata;
  logic        rsp_valid, rsp_err, busy, phy_mdc, phy_mdio_o, phy_mdio_oe, phy_mdio_i;
  logic [15:0] rsp_rdata;

  logic        b_cmd_valid, b_cmd_ready, b_cmd_write;
  logic [4:0]  b_cmd_phy_addr, b_cmd_reg_addr;
  logic [15:0] b_cmd_wdata;
  logic        b_rsp_valid, b_rsp_err, b_busy, b_phy_mdc, b_phy_mdio_o, b_phy_mdio_oe, b_phy_mdio_i;
  logic [15:0] b_rsp_rdata;

  eth_mdio_master #(.CLK_DIV(CD), .PREAMBLE_LEN(PRE)) dut (
    .msoc_clk(clk), .rst_int(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_phy_addr(cmd_phy_addr), .cmd_reg_addr(cmd_reg_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .phy_mdc(phy_mdc), .phy_mdio_o(phy_mdio_o), .phy_mdio_oe(phy_mdio_oe), .phy_mdio_i(phy_mdio_i)
  );

  eth_mdio_master #(.CLK_DIV(CD_B), .PREAMBLE_LEN(0)) dut_b (
    .msoc_clk(clk), .rst_int(rst),
    .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_write(b_cmd_write),
    .cmd_phy_addr(b_cmd_phy_addr), .cmd_reg_addr(b_cmd_reg_addr), .cmd_wdata(b_cmd_wdata),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err), .busy(b_busy),
    .phy_mdc(b_phy_mdc), .phy_mdio_o(b_phy_mdio_o), .phy_mdio_oe(b_phy_mdio_oe), .phy_mdio_i(b_phy_mdio_i)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // PHY model controls (written by the stimulus thread only).
  bit          phy_mode = 1'b0;   // 1 = PHY present and answering, 0 = MDIO pulled high
  logic [15:0] phy_data = 16'h0;

  // Monitor state (written by the monitor thread only).
  int   gcyc = 0, rise_cnt = 0, run_len = 0, short_cnt = 0;
  bit   mdc_prev = 1'b0, ready_prev = 1'b1;
  int   acc_q[$], rsp_q[$];
  logic [15:0] rd_q[$];
  bit   er_q[$], o_q[$], oe_q[$];
  bit   b_mdc_prev = 1'b0, b_ready_prev = 1'b1;
  int   b_acc_q[$], b_rsp_q[$];
  bit   b_o_q[$];

  // Value the PHY puts on MDIO for frame bit k (main instance).
  function automatic bit phy_bit(input int k);
    int j;
    if (phy_mode && k == PRE + 15) return 1'b0;
    if (phy_mode && k >= PRE + 16 && k < PRE + 32) begin
      j = 15 - (k - PRE - 16);
      return phy_data[j];
    end
    return 1'b1;
  endfunction

  // Monitor + PHY model, sampling mid-cycle on the falling clock edge.
  initial begin
    phy_mdio_i   = 1'b1;
    b_phy_mdio_i = 1'b1;
    forever begin
      @(negedge clk);
      gcyc++;
      if (ready_prev && !cmd_ready) begin acc_q.push_back(gcyc - 1); rise_cnt = 0; end
      if (rsp_valid) begin rsp_q.push_back(gcyc); rd_q.push_back(rsp_rdata); er_q.push_back(rsp_err); end
      if (phy_mdc && !mdc_prev) begin o_q.push_back(phy_mdio_o); oe_q.push_back(phy_mdio_oe); rise_cnt++; end
      if (!phy_mdc && mdc_prev) phy_mdio_i = phy_bit(rise_cnt);
      if (phy_mdc != mdc_prev) begin
        if (run_len < CD) short_cnt++;
        run_len = 1;
      end else begin
        run_len++;
      end
      mdc_prev   = phy_mdc;
      ready_prev = cmd_ready;
      if (b_ready_prev && !b_cmd_ready) b_acc_q.push_back(gcyc - 1);
      if (b_rsp_valid) b_rsp_q.push_back(gcyc);
      if (b_phy_mdc && !b_mdc_prev) b_o_q.push_back(b_phy_mdio_o);
      b_mdc_prev   = b_phy_mdc;
      b_ready_prev = b_cmd_ready;
    end
  end

  // Reference frame: what MDIO must show at each MDC rise, and whether it is driven.
  function automatic void exp_frame(input bit wr, input logic [4:0] pa, input logic [4:0] ra,
                                    input logic [15:0] d, output logic [63:0] o, output logic [63:0] oe);
    bit q[$];
    bit e[$];
    repeat (32) q.push_back(1'b1);
    q.push_back(1'b0); q.push_back(1'b1);
    if (wr) begin q.push_back(1'b0); q.push_back(1'b1); end
    else    begin q.push_back(1'b1); q.push_back(1'b0); end
    for (int i = 4; i >= 0; i--) q.push_back(pa[i]);
    for (int i = 4; i >= 0; i--) q.push_back(ra[i]);
    repeat (46) e.push_back(1'b1);
    if (wr) begin
      q.push_back(1'b1); q.push_back(1'b0);
      for (int i = 15; i >= 0; i--) q.push_back(d[i]);
      repeat (18) e.push_back(1'b1);
    end else begin
      repeat (18) begin q.push_back(1'b0); e.push_back(1'b0); end
    end
    for (int i = 0; i < 64; i++) begin o[63 - i] = q[i]; oe[63 - i] = e[i]; end
  endfunction

  task automatic drive_cmd(input bit wr, input logic [4:0] pa, input logic [4:0] ra, input logic [15:0] d);
    cmd_write = wr; cmd_phy_addr = pa; cmd_reg_addr = ra; cmd_wdata = d;
  endtask

  // Compare one completed frame (starting at o_q index b0) and its response against the model.
  task automatic check_frame(input string tag, input bit wr, input logic [4:0] pa, input logic [4:0] ra,
                             input logic [15:0] d, input bit mode, input logic [15:0] pd,
                             input int b0, input int ai, input int ri);
    logic [63:0] eo, eoe, go, goe;
    exp_frame(wr, pa, ra, d, eo, eoe);
    go = '0; goe = '0;
    check({tag, "_nbits"}, 64'(o_q.size() >= b0 + NB), 64'd1);
    if (o_q.size() < b0 + NB) return;
    for (int i = 0; i < NB; i++) begin go[63 - i] = o_q[b0 + i]; goe[63 - i] = oe_q[b0 + i]; end
    check({tag, "_mdio"}, go, eo);
    check({tag, "_oe"}, goe, eoe);
    check({tag, "_lat"}, 64'(rsp_q[ri] - acc_q[ai]), 64'(LAT));
    check({tag, "_rdata"}, 64'(rd_q[ri]), 64'(wr ? 16'h0000 : (mode ? pd : 16'hFFFF)));
    check({tag, "_err"}, 64'(er_q[ri]), 64'(wr ? 1'b0 : !mode));
  endtask

  task automatic run_cmd(input string tag, input bit wr, input logic [4:0] pa, input logic [4:0] ra,
                         input logic [15:0] d, input bit mode, input logic [15:0] pd);
    int a0, r0, b0, t;
    logic [15:0] exp_rd;
    a0 = acc_q.size(); r0 = rsp_q.size(); b0 = o_q.size();
    phy_mode = mode; phy_data = pd;
    @(negedge clk);
    cmd_valid = 1'b1;
    drive_cmd(wr, pa, ra, d);
    t = 0;
    while (acc_q.size() == a0 && t < 1000) begin @(posedge clk); t++; end
    check({tag, "_accept"}, 64'(acc_q.size() > a0), 64'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    drive_cmd(1'($urandom), 5'($urandom), 5'($urandom), 16'($urandom));
    if (acc_q.size() == a0) return;
    t = 0;
    while (rsp_q.size() == r0 && t < 2000) begin @(posedge clk); t++; end
    check({tag, "_done"}, 64'(rsp_q.size() > r0), 64'd1);
    if (rsp_q.size() == r0) return;
    check_frame(tag, wr, pa, ra, d, mode, pd, b0, a0, r0);
    exp_rd = wr ? 16'h0000 : (mode ? pd : 16'hFFFF);
    repeat (3) @(negedge clk);
    check({tag, "_hold"}, 64'(rsp_rdata), 64'(exp_rd));
  endtask

  initial begin
    int a0, r0, b0, s0, t;
    logic [63:0] eo, eoe, go;
    rst = 1'b0;
    cmd_valid = 1'b0; b_cmd_valid = 1'b0;
    drive_cmd(1'b0, 5'd0, 5'd0, 16'h0);
    b_cmd_write = 1'b0; b_cmd_phy_addr = 5'd0; b_cmd_reg_addr = 5'd0; b_cmd_wdata = 16'h0;
    #2 rst = 1'b1;
    #1;
    check("reset_state", {cmd_ready, busy, rsp_valid, rsp_err, phy_mdc, phy_mdio_o, phy_mdio_oe, rsp_rdata},
          {7'b1000000, 16'h0000});
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Directed frames from the block's intended use.
    run_cmd("wr_bmcr", 1'b1, 5'd1, 5'd0, 16'h1140, 1'b1, 16'h0);
    run_cmd("rd_phyid", 1'b0, 5'd1, 5'd2, 16'h0, 1'b1, 16'h0141);
    run_cmd("rd_nophy", 1'b0, 5'd1, 5'd2, 16'h0, 1'b0, 16'h0);

    // Randomized frames.
    for (int n = 0; n < 6; n++) begin
      run_cmd($sformatf("rnd%0d", n), 1'($urandom), 5'($urandom), 5'($urandom), 16'($urandom),
              $urandom_range(0, 3) != 0, 16'($urandom));
    end

    // Back-to-back: write then read with cmd_valid held high across both.
    a0 = acc_q.size(); r0 = rsp_q.size(); b0 = o_q.size(); s0 = short_cnt;
    phy_mode = 1'b1; phy_data = 16'hA5C3;
    @(negedge clk);
    cmd_valid = 1'b1;
    drive_cmd(1'b1, 5'd3, 5'd9, 16'h5AA5);
    t = 0;
    while (acc_q.size() == a0 && t < 1000) begin @(posedge clk); t++; end
    @(negedge clk);
    drive_cmd(1'b0, 5'd4, 5'd17, 16'h0);
    t = 0;
    while (acc_q.size() < a0 + 2 && t < 2000) begin @(posedge clk); t++; end
    @(negedge clk);
    cmd_valid = 1'b0;
    t = 0;
    while (rsp_q.size() < r0 + 2 && t < 2000) begin @(posedge clk); t++; end
    check("b2b_done", 64'(rsp_q.size() >= r0 + 2), 64'd1);
    if (rsp_q.size() >= r0 + 2) begin
      check("b2b_accept_in_rsp", 64'(acc_q[a0 + 1]), 64'(rsp_q[r0]));
      check("b2b_accept_gap", 64'(acc_q[a0 + 1] - acc_q[a0]), 64'(LAT));
      check_frame("b2b_wr", 1'b1, 5'd3, 5'd9, 16'h5AA5, 1'b1, 16'hA5C3, b0, a0, r0);
      check_frame("b2b_rd", 1'b0, 5'd4, 5'd17, 16'h0, 1'b1, 16'hA5C3, b0 + NB, a0 + 1, r0 + 1);
      check("b2b_mdc_short", 64'(short_cnt - s0), 64'd0);
    end

    // No-preamble instance: first MDC rise must carry ST bit 0.
    b0 = b_o_q.size(); a0 = b_acc_q.size(); r0 = b_rsp_q.size();
    @(negedge clk);
    b_cmd_valid = 1'b1; b_cmd_write = 1'b1; b_cmd_phy_addr = 5'd22; b_cmd_reg_addr = 5'd13; b_cmd_wdata = 16'hBEEF;
    t = 0;
    while (b_acc_q.size() == a0 && t < 1000) begin @(posedge clk); t++; end
    @(negedge clk);
    b_cmd_valid = 1'b0;
    t = 0;
    while (b_rsp_q.size() == r0 && t < 2000) begin @(posedge clk); t++; end
    check("nopre_done", 64'(b_rsp_q.size() > r0), 64'd1);
    if (b_rsp_q.size() > r0 && b_o_q.size() >= b0 + 32) begin
      exp_frame(1'b1, 5'd22, 5'd13, 16'hBEEF, eo, eoe);
      go = '0;
      for (int i = 0; i < 32; i++) go[31 - i] = b_o_q[b0 + i];
      check("nopre_first_bit", 64'(b_o_q[b0]), 64'd0);
      check("nopre_mdio", go, {32'h0, eo[31:0]});
      check("nopre_lat", 64'(b_rsp_q[r0] - b_acc_q[a0]), 64'(LAT_B));
      check("nopre_rdata", 64'(b_rsp_rdata), 64'd0);
    end

    // Reset around bit 20 of a read aborts the frame without a response.
    a0 = acc_q.size(); r0 = rsp_q.size();
    phy_mode = 1'b1; phy_data = 16'h1234;
    @(negedge clk);
    cmd_valid = 1'b1;
    drive_cmd(1'b0, 5'd7, 5'd1, 16'h0);
    t = 0;
    while (acc_q.size() == a0 && t < 1000) begin @(posedge clk); t++; end
    @(negedge clk);
    cmd_valid = 1'b0;
    t = 0;
    while (rise_cnt < 20 && t < 1000) begin @(posedge clk); t++; end
    check("abort_reached_bit20", 64'(rise_cnt >= 20), 64'd1);
    #1 rst = 1'b1;
    #1;
    check("abort_state", {cmd_ready, busy, rsp_valid, phy_mdc, phy_mdio_o, phy_mdio_oe, rsp_rdata},
          {6'b100000, 16'h0000});
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (300) @(negedge clk);
    check("abort_no_rsp", 64'(rsp_q.size()), 64'(r0));
    run_cmd("after_abort", 1'b0, 5'd7, 5'd1, 16'h0, 1'b1, 16'h1234);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
